// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte receive buffer behind the UART receiver.
// Circular FIFO with show-ahead read, overflow and timeout interrupt.
module uart_rx_fifo #(
    parameter int          DEPTH   = 16,
    parameter int          ADDR_W  = 4,
    parameter int          THRESH  = 8,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_end,
    input  logic [7:0]        rx_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic              tmo,
    output logic              irq
);

    localparam logic [ADDR_W:0]   DEPTH_C  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   THRESH_C = THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_tmo;
    logic [15:0]       r_tmo_cnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Occupancy flags and the accepted push/pop/drop decisions
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == DEPTH_C);
        w_pop   = rd_en && !w_empty;
        w_push  = rx_end && (!w_full || w_pop);
        w_drop  = rx_end && w_full && !rd_en;
    end

    // Storage array, written on every accepted push; not reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Read/write pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Fill level: up on push only, down on pop only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Character timeout: idle countdown while data sits in the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= TIMEOUT;
            r_tmo     <= 1'b0;
        end else if (w_push || w_pop || w_empty) begin
            r_tmo_cnt <= TIMEOUT;
            r_tmo     <= 1'b0;
        end else if (r_tmo_cnt != 16'd0) begin
            r_tmo_cnt <= r_tmo_cnt - 16'd1;
        end else begin
            r_tmo     <= 1'b1;
        end
    end

    // Show-ahead read data and status outputs
    always_comb begin
        rd_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
        empty   = w_empty;
        full    = w_full;
        count   = r_count;
        ovf     = r_ovf;
        tmo     = r_tmo;
        irq     = (r_count >= THRESH_C) || r_tmo || r_ovf;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer placed directly downstream of the UART receiver. It captures each completed byte, signalled by the receiver's one-cycle receive-complete pulse and byte data, into a DEPTH-entry circular FIFO. It presents the oldest byte to the bus-side reader with a pop strobe. It also raises an interrupt request on threshold, character-timeout or overflow, so the CPU need not poll per byte.

## Interface
- DEPTH, 16: number of byte entries; power of two, 4..256.
- ADDR_W, 4: log2(DEPTH).
- THRESH, 8: fill level (1..DEPTH) at or above which the threshold interrupt is active.
- TIMEOUT, 16'd1000: idle cycles with data buffered before the timeout flag sets; 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_end  in  1  byte-complete pulse from the receiver; one cycle per byte.
- rx_data  in  8  received byte; valid in the cycle rx_end=1.
- rd_en  in  1  pop strobe from the bus side; one pop per high cycle.
- rd_data  out  8  oldest buffered byte; 8'h00 when empty.
- empty  out  1  no bytes buffered.
- full  out  1  DEPTH bytes buffered.
- count  out  ADDR_W+1  number of bytes buffered, 0..DEPTH.
- ovf  out  1  sticky overflow flag; a byte was dropped.
- ovf_clr  in  1  clears ovf.
- tmo  out  1  character-timeout flag.
- irq  out  1  interrupt request = (count >= THRESH) | tmo | ovf.

## Operation
- Storage: DEPTH x 8 array, wr_ptr and rd_ptr of ADDR_W bits that wrap modulo DEPTH, and a registered count of ADDR_W+1 bits. empty = (count==0). full = (count==DEPTH). The array itself is not reset.
- Push: when rx_end=1 and the FIFO is not full, write mem[wr_ptr] <= rx_data and increment wr_ptr.
- Push when full: if rd_en=0 in the same cycle, drop the byte, set ovf, and leave pointers and count unchanged.
- Pop: when rd_en=1 and the FIFO is not empty, increment rd_ptr. rd_en while empty is ignored, with no error flag.
- Simultaneous push and pop:
  - Not empty: both take effect; count unchanged.
  - Full: push is accepted and ovf is not set; count stays DEPTH.
  - Empty: pop is ignored, push is accepted, count becomes 1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- rd_data = mem[rd_ptr] when !empty, else 8'h00. It is a show-ahead output with combinational read from registered pointers.
- ovf: set wins over ovf_clr in the same cycle. Otherwise ovf_clr=1 clears it.
- Timeout counter (16 bits):
  - Reloads to TIMEOUT on any accepted push or pop, or when empty.
  - When !empty and the counter is non-zero, it decrements by 1 per cycle.
  - When !empty and the counter is zero, tmo sets to 1.
  - tmo clears on any accepted push or pop, or when the FIFO goes empty.
- irq is combinational from registered state; there is no edge detection.

## Timing
- Reset values: empty=1, full=0, count=0, rd_data=8'h00, ovf=0, tmo=0, irq=0; wr_ptr=rd_ptr=0; timeout counter=TIMEOUT.
- Push latency: rx_end sampled at edge N, so empty=0, count+1 and valid rd_data are visible after edge N.
- Pop: with rd_en high across edge N, the next byte (or 8'h00 and empty=1) appears after edge N. A reader samples rd_data before asserting rd_en, or in the same cycle.
- Back-to-back rx_end in consecutive cycles is accepted, one byte per cycle.
- Timeout: the last push/pop occurs at edge N with no further activity. tmo rises after edge N+TIMEOUT+1.
- Reset mid-operation discards all buffered data and flags immediately.
- Pointer wrap: after DEPTH pushes and DEPTH pops, wr_ptr=rd_ptr=0 again. Data order is preserved across the wrap.

## Test plan
- Reset, then push 8'hA5 and 8'h3C on consecutive cycles -> count=2, rd_data=8'hA5; rd_en for 1 cycle -> rd_data=8'h3C, count=1; second pop -> empty=1, rd_data=8'h00.
- Push 16 bytes 8'h00..8'h0F -> full=1, irq=1 from count 8 onward; push 8'hFF -> ovf=1 and count=16; pops return 8'h00..8'h0F in order; ovf_clr -> ovf=0.
- Full FIFO with rx_end and rd_en in the same cycle -> ovf stays 0, count=16, the new byte is read last; empty FIFO with both -> count=1, rd_data equals the pushed byte.
- Push 8'h55 with TIMEOUT=16 and no further activity -> tmo=1 and irq=1 exactly 17 cycles after the push edge; pop -> tmo=0, irq=0.
- Push 20 and pop 20 interleaved so the pointers wrap -> every byte is read back in order; rd_en on empty -> count stays 0 with no flag; ovf_clr asserted in the same cycle as an overflow -> ovf=1.
- Assert reset low asynchronously while holding 5 bytes and ovf=1 -> all outputs take their reset values before the next clock edge.
